// File: rtl/wb_writeback_arb.sv
// ---------------------------------------------------------------------------
// wb_writeback_arb
//
// Write-side master of the register file. This block merges two sources of
// results. Single-cycle ALU results are written directly. Variable-latency
// LSU load returns are first buffered in a small circular queue. The block
// issues at most one registered regfile write per cycle, and writes to x0
// are suppressed.
//
// Arbitration, with one winner per cycle:
//   1. The queue is full: the queue head wins and the ALU is stalled.
//   2. Otherwise, a valid ALU result wins.
//   3. Otherwise, a non-empty queue pops its head.
//   4. Otherwise, the block is idle.
//
// Parameters
//   LQ_DEPTH  load-return queue depth (power of two, >= 2)
//   DATA_W    result / register data width
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   alu_valid_i/alu_rd_i/alu_data_i     ALU result
//   alu_stall_o                         ALU result not consumed this cycle
//   lsu_valid_i/lsu_rd_i/lsu_data_i     load return
//   lsu_ready_o                         queue accepts a load return
//   rd_addr_o/rd_data_o/rd_wren_o       registered regfile write port
//   lq_count_o                          entries currently queued
//
// Optional feature (macro WB_FWD_EN)
//   Adds the fwd_rs{1,2}_* ports. They forward the pending output-register
//   write to two read ports. With the macro undefined, these ports and the
//   compare logic are absent.
// ---------------------------------------------------------------------------
module wb_writeback_arb #(
  parameter int LQ_DEPTH = 4,
  parameter int DATA_W   = 32,
  localparam int CW      = $clog2(LQ_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alu_valid_i,
  input  logic [4:0]        alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_stall_o,
  input  logic              lsu_valid_i,
  input  logic [4:0]        lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              lsu_ready_o,
`ifdef WB_FWD_EN
  input  logic [4:0]        fwd_rs1_addr_i,
  input  logic [4:0]        fwd_rs2_addr_i,
  output logic              fwd_rs1_hit_o,
  output logic              fwd_rs2_hit_o,
  output logic [DATA_W-1:0] fwd_rs1_data_o,
  output logic [DATA_W-1:0] fwd_rs2_data_o,
`endif
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_wren_o,
  output logic [CW-1:0]     lq_count_o
);

  localparam int            AW       = $clog2(LQ_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         mem_q [LQ_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_wren_q;

  logic      full, empty, push, pop, alu_win, win;
  wb_entry_t win_entry;

  // Ready and stall depend only on the registered count. This keeps the
  // upstream handshakes free of paths that pass through the arbiter.
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign lsu_ready_o = ~full;
  assign alu_stall_o = alu_valid_i & full;

  assign push    = lsu_valid_i & ~full;
  assign alu_win = alu_valid_i & ~full;
  // A full queue always drains, so a load is never blocked for more than one
  // cycle. Otherwise the head pops only when the ALU is not using the slot.
  assign pop     = full | (~alu_valid_i & ~empty);
  assign win     = alu_win | pop;

  always_comb begin
    win_entry = mem_q[rd_ptr_q];
    if (alu_win) win_entry = '{rd: alu_rd_i, data: alu_data_i};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: queue storage has no reset; validity is tracked solely by the
  // pointers and the count, so resetting the array would only add area.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: lsu_rd_i, data: lsu_data_i};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge values of the other registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wren_q <= 1'b0;
    end else begin
      // The pointers wrap naturally because the depth is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (win) begin
        // An x0 entry is consumed but never produces a write strobe.
        rd_addr_q <= win_entry.rd;
        rd_data_q <= win_entry.data;
        rd_wren_q <= (win_entry.rd != 5'd0);
      end else begin
        rd_wren_q <= 1'b0;
      end
    end
  end

  assign rd_addr_o  = rd_addr_q;
  assign rd_data_o  = rd_data_q;
  assign rd_wren_o  = rd_wren_q;
  assign lq_count_o = count_q;

`ifdef WB_FWD_EN
  // Bypasses the write held in the output register, which the regfile has
  // not yet absorbed in this cycle.
  assign fwd_rs1_hit_o  = rd_wren_q & (fwd_rs1_addr_i == rd_addr_q) & (fwd_rs1_addr_i != 5'd0);
  assign fwd_rs2_hit_o  = rd_wren_q & (fwd_rs2_addr_i == rd_addr_q) & (fwd_rs2_addr_i != 5'd0);
  assign fwd_rs1_data_o = fwd_rs1_hit_o ? rd_data_q : '0;
  assign fwd_rs2_data_o = fwd_rs2_hit_o ? rd_data_q : '0;
`endif

endmodule
